ma_ctrl: RTL and testbench

//  Sequencer for the moving-average (MA) filter stage fed by the CMUL output.

---
 rtl/ma_ctrl_if.sv | 34 +++
 rtl/ma_ctrl.sv | 94 +++++++++
 tb/tb_ma_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ma_ctrl_if.sv
// ma_ctrl_if: command, sample handshake, MA datapath strobe and status bundle
// for the moving-average sequencer.
//   cmd_start / cmd_stop : one-cycle commands toward the controller
//   in_valid / in_ready  : upstream sample handshake (CMUL -> MA)
//   ma_en / ma_clr       : enable strobe and clear pulse to the MA datapath
//   out_valid / out_ready: full-window average handshake toward downstream
//   busy / filled        : controller status
//   resync_count         : saturating count of clear/refill cycles since start
// master = the side that issues commands and samples; slave = the controller.
interface ma_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cmd_start;
  logic             cmd_stop;
  logic             in_valid;
  logic             in_ready;
  logic             ma_en;
  logic             ma_clr;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             filled;
  logic [CNT_W-1:0] resync_count;

  modport master (
    output cmd_start, cmd_stop, in_valid, out_ready,
    input  in_ready, ma_en, ma_clr, out_valid, busy, filled, resync_count
  );

  modport slave (
    input  cmd_start, cmd_stop, in_valid, out_ready,
    output in_ready, ma_en, ma_clr, out_valid, busy, filled, resync_count
  );
endinterface

// File: rtl/ma_ctrl.sv
// ma_ctrl: sequencer for the moving-average filter stage behind the CMUL.
// Accepts samples over a valid/ready handshake, strobes the MA enable once per
// accepted sample, clears the MA on start and on every resync, hides warm-up
// averages and periodically forces a clear/refill to bound running-sum drift.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-low
//   bus  : ma_ctrl_if slave modport (commands, sample/average handshakes,
//          MA strobes, busy/filled status, resync_count)
module ma_ctrl #(
  parameter int MA_SNAPSHOT_COUNT = 4,
  parameter int RESYNC_PERIOD     = 1024,
  parameter int CNT_W             = 16
) (
  input  logic        clk,
  input  logic        rst,
  ma_ctrl_if.slave    bus
);

  localparam int               FILL_W    = $clog2(MA_SNAPSHOT_COUNT);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(MA_SNAPSHOT_COUNT - 1);
  localparam bit               RESYNC_EN = (RESYNC_PERIOD != 0);
  localparam logic [CNT_W-1:0] RUN_LAST  = RESYNC_EN ? CNT_W'(RESYNC_PERIOD - 1) : '0;

  typedef enum logic [1:0] {IDLE, CLEAR, FILL, RUN} state_t;

  state_t            state, state_nxt;
  logic [FILL_W-1:0] fill_cnt;
  logic [CNT_W-1:0]  run_cnt;
  logic [CNT_W-1:0]  resync_cnt;
  logic              vld_p1;
  logic              resync_pend;
  logic              acc;
  logic              fill_last;
  logic              run_last;

  // Accepting stops once a resync is scheduled so the last RUN average can drain.
  assign bus.in_ready = (state == FILL || state == RUN) && !resync_pend &&
                        (!vld_p1 || bus.out_ready);
  assign acc          = bus.in_valid && bus.in_ready;
  assign fill_last    = (state == FILL) && (fill_cnt == FILL_LAST);
  assign run_last     = RESYNC_EN && (state == RUN) && (run_cnt == RUN_LAST);

  assign bus.ma_en        = acc;
  // MA clear follows reset combinationally so the datapath is held clear throughout.
  assign bus.ma_clr       = !rst || (state == CLEAR);
  assign bus.out_valid    = vld_p1;
  assign bus.busy         = (state != IDLE);
  assign bus.filled       = (state == RUN);
  assign bus.resync_count = resync_cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.cmd_start) state_nxt = CLEAR;
      CLEAR: state_nxt = FILL;
      FILL:  if (acc && fill_last) state_nxt = RUN;
      RUN:   if (resync_pend && (!vld_p1 || bus.out_ready)) state_nxt = CLEAR;
      default: state_nxt = IDLE;
    endcase
    if (bus.cmd_stop) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      fill_cnt    <= '0;
      run_cnt     <= '0;
      resync_cnt  <= '0;
      vld_p1      <= 1'b0;
      resync_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bus.cmd_stop || state == CLEAR) begin
        fill_cnt    <= '0;
        run_cnt     <= '0;
        vld_p1      <= 1'b0;
        resync_pend <= 1'b0;
      end else begin
        if (state == IDLE && bus.cmd_start) resync_cnt <= '0;
        if (acc && state == FILL) fill_cnt <= fill_cnt + 1'b1;
        if (acc && state == RUN)  run_cnt  <= run_cnt + 1'b1;
        // Stage boundary: average is valid one cycle after the enable that completed it.
        if (acc && (fill_last || state == RUN)) vld_p1 <= 1'b1;
        else if (bus.out_ready)                 vld_p1 <= 1'b0;
        if (acc && run_last) begin
          resync_pend <= 1'b1;
          if (resync_cnt != '1) resync_cnt <= resync_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ma_ctrl.sv
module tb_ma_ctrl;
  localparam int N  = 4;
  localparam int P  = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ma_ctrl_if #(.CNT_W(CW)) bus ();

  ma_ctrl #(
    .MA_SNAPSHOT_COUNT(N),
    .RESYNC_PERIOD    (P),
    .CNT_W            (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int q[$];
  bit mon_on = 1'b0;
  int en_cnt = 0;
  int k      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic s, input logic p, input logic v, input logic r);
    @(negedge clk);
    bus.cmd_start = s;
    bus.cmd_stop  = p;
    bus.in_valid  = v;
    bus.out_ready = r;
  endtask

  // Reference: after a start, samples come in cycles of N+P; the last N+P-N+1
  // positions of each cycle (from the window-completing fill sample on) yield an
  // average, and every completed cycle is one resync.
  function automatic bit produces_output(input int idx);
    return (idx % (N + P)) >= (N - 1);
  endfunction

  function automatic int exp_resync(input int idx);
    int v;
    v = (idx + 1) / (N + P);
    return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
  endfunction

  // Monitor: checks out_valid against outstanding expectations, and each
  // consumed average against the sample that should have produced it.
  initial begin
    int exp_k;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) chk("out_valid_vs_model", bus.out_valid, (q.size() != 0));
      @(negedge clk);
      #2;
      if (mon_on) begin
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) chk("unexpected_output", 1, 0);
          else begin
            exp_k = q.pop_front();
            chk("output_sample_id", en_cnt - 1, exp_k);
            chk("resync_at_output", bus.resync_count, exp_resync(exp_k));
          end
        end
        if (bus.ma_en) en_cnt++;
      end
    end
  end

  initial begin
    bit acc;
    bit got_run;
    rst = 1'b0;
    bus.cmd_start = 1'b0;
    bus.cmd_stop  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready",  bus.in_ready, 0);
    chk("rst_ma_en",     bus.ma_en, 0);
    chk("rst_ma_clr",    bus.ma_clr, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_filled",    bus.filled, 0);
    chk("rst_resync",    bus.resync_count, 0);

    @(negedge clk); rst = 1'b1;
    tick();
    chk("idle_ma_clr", bus.ma_clr, 0);

    // Start, then four back-to-back samples with out_ready high.
    drv(1, 0, 0, 1); tick();
    chk("clear_ma_clr", bus.ma_clr, 1);
    chk("clear_busy",   bus.busy, 1);
    drv(0, 0, 0, 1); tick();
    chk("fill_ma_clr_done", bus.ma_clr, 0);
    chk("fill_in_ready",    bus.in_ready, 1);
    for (int i = 0; i < N; i++) begin
      drv(0, 0, 1, 1); #1;
      chk("fill_ma_en", bus.ma_en, 1);
      tick();
      chk("fill_filled",    bus.filled, (i == N - 1));
      chk("fill_out_valid", bus.out_valid, (i == N - 1));
    end

    // Backpressure: held average blocks acceptance until consumed.
    drv(0, 0, 1, 0); #1;
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_ma_en",    bus.ma_en, 0);
    tick();
    chk("bp_out_valid_held", bus.out_valid, 1);
    drv(0, 0, 1, 1); #1;
    chk("bp_resume_ma_en", bus.ma_en, 1);
    tick();
    chk("bp_new_valid", bus.out_valid, 1);

    // Stop in RUN with a pending average; same-cycle sample still gets its enable.
    drv(0, 1, 1, 1); #1;
    chk("stop_run_ma_en", bus.ma_en, 1);
    tick();
    chk("stop_run_busy",      bus.busy, 0);
    chk("stop_run_out_valid", bus.out_valid, 0);
    chk("stop_run_filled",    bus.filled, 0);

    // Stop in FILL after two samples, then a fresh start.
    drv(1, 0, 0, 1); tick();
    drv(0, 0, 1, 1); tick();
    drv(0, 0, 1, 1); tick();
    drv(0, 0, 1, 1); tick();
    drv(0, 1, 0, 1); tick();
    chk("stop_fill_busy",      bus.busy, 0);
    chk("stop_fill_out_valid", bus.out_valid, 0);
    drv(1, 0, 0, 1); tick();
    chk("restart_ma_clr", bus.ma_clr, 1);
    chk("restart_busy",   bus.busy, 1);

    // Randomized run with resync, checked by the scoreboard.
    @(negedge clk);
    bus.cmd_start = 1'b0;
    bus.in_valid  = 1'b0;
    en_cnt = 0;
    k      = 0;
    mon_on = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      #1;
      acc = bus.in_valid && bus.in_ready;
      chk("rand_ma_en", bus.ma_en, acc);
      if (acc) begin
        if (produces_output(k)) q.push_back(k);
        k++;
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    mon_on = 1'b0;
    chk("drain_queue_empty", q.size(), 0);
    chk("enough_accepted",   (k >= 100), 1);
    chk("resync_total",      bus.resync_count, k / (N + P));

    // Reach RUN, then pulse reset for one cycle.
    got_run = 1'b0;
    for (int c = 0; c < 30 && !got_run; c++) begin
      drv(0, 0, 1, 1); tick();
      got_run = bus.filled;
    end
    chk("reach_run", got_run, 1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("mid_rst_busy",      bus.busy, 0);
    chk("mid_rst_filled",    bus.filled, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_in_ready",  bus.in_ready, 0);
    chk("mid_rst_ma_clr",    bus.ma_clr, 1);
    chk("mid_rst_resync",    bus.resync_count, 0);

    // Start and stop together from IDLE stays IDLE.
    @(negedge clk);
    rst = 1'b1;
    bus.cmd_start = 1'b1;
    bus.cmd_stop  = 1'b1;
    bus.in_valid  = 1'b0;
    tick();
    chk("start_stop_busy",   bus.busy, 0);
    chk("start_stop_ma_clr", bus.ma_clr, 0);
    drv(0, 0, 0, 0); tick();
    chk("start_stop_still_idle", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
